// File: rtl/fixed_point_adder_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fixed_point_adder_pipe                                                   |
// | Two-stage valid/ready sign-magnitude adder c = a + b with overflow flag. |
// | Optional: define FXP_ADD_SAT_EN to saturate same-sign overflow.         |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module fixed_point_adder_pipe #(
  parameter int Q = 15,
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] c,
  output logic         ovf
);

  localparam logic [N-2:0] c_MAG_MAX = '1;

  // Q only describes the binary point; it never changes the arithmetic.
  logic w_unused_q;
  assign w_unused_q = (Q >= 0);

  logic         w_en;
  logic [N-2:0] w_ma;
  logic [N-2:0] w_mb;
  logic         w_sign_a;
  logic         w_sign_b;

  logic         r_s1_valid;
  logic         r_sign_a;
  logic         r_sign_b;
  logic [N-1:0] r_sum;
  logic [N-2:0] r_diff_ab;
  logic [N-2:0] r_diff_ba;
  logic         r_a_ge_b;

  logic         w_same;
  logic         w_ovf;
  logic [N-2:0] w_mag;
  logic         w_sign;

  logic         r_out_valid;
  logic [N-1:0] r_c;
  logic         r_ovf;

  assign w_en     = !r_out_valid || out_ready;
  assign in_ready = w_en;

  assign w_ma = a[N-2:0];
  assign w_mb = b[N-2:0];
  // A negative zero operand is folded to +0 before it reaches the datapath.
  assign w_sign_a = a[N-1] && (w_ma != '0);
  assign w_sign_b = b[N-1] && (w_mb != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_sign_a   <= 1'b0;
      r_sign_b   <= 1'b0;
      r_sum      <= '0;
      r_diff_ab  <= '0;
      r_diff_ba  <= '0;
      r_a_ge_b   <= 1'b0;
    end else if (w_en) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_sign_a  <= w_sign_a;
        r_sign_b  <= w_sign_b;
        r_sum     <= {1'b0, w_ma} + {1'b0, w_mb};
        r_diff_ab <= w_ma - w_mb;
        r_diff_ba <= w_mb - w_ma;
        r_a_ge_b  <= (w_ma >= w_mb);
      end
    end
  end

  assign w_same = (r_sign_a == r_sign_b);
  assign w_ovf  = w_same && r_sum[N-1];

  always_comb begin
    w_mag = r_sum[N-2:0];
    if (w_same) begin
      if (w_ovf) begin
`ifdef FXP_ADD_SAT_EN
        w_mag = c_MAG_MAX;
`else
        w_mag = r_sum[N-2:0];
`endif
      end
    end else begin
      w_mag = r_a_ge_b ? r_diff_ab : r_diff_ba;
    end
  end

  // Zero magnitude always leaves as +0.
  assign w_sign = ((w_same || r_a_ge_b) ? r_sign_a : r_sign_b) && (w_mag != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_c         <= '0;
      r_ovf       <= 1'b0;
    end else if (w_en) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_c   <= {w_sign, w_mag};
        r_ovf <= w_ovf;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign c         = r_c;
  assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_fixed_point_adder_pipe.sv
`default_nettype none
// Testbench for fixed_point_adder_pipe: scoreboard of expected results,
// filled on input acceptance and drained by an output monitor.
module tb_fixed_point_adder_pipe;

  localparam int N = 32;
  localparam int Q = 15;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] c;
  logic         ovf;

  fixed_point_adder_pipe #(.Q(Q), .N(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .c        (c),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] c;
    logic         ovf;
    int           cyc;
    bit           lat;
  } exp_t;

  exp_t sb[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_out = 0;

  bit           lat_check;
  bit           dir_valid;
  logic [N-1:0] dir_c;
  logic         dir_ovf;
  bit           bp_on;

  bit           prev_stall;
  logic [N-1:0] prev_c;
  logic         prev_ovf;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: signed arithmetic on the represented values.
  function automatic logic [N:0] model(input logic [N-1:0] x, input logic [N-1:0] y);
    longint va, vb, s, mag;
    logic   neg, ov;
    logic [63:0] m;
    va = longint'(x[N-2:0]);
    vb = longint'(y[N-2:0]);
    if (x[N-1]) va = -va;
    if (y[N-1]) vb = -vb;
    s   = va + vb;
    neg = (s < 0);
    mag = neg ? -s : s;
    ov  = (mag >= (longint'(1) <<< (N-1)));
    if (ov) begin
`ifdef FXP_ADD_SAT_EN
      mag = (longint'(1) <<< (N-1)) - 1;
`else
      mag = mag - (longint'(1) <<< (N-1));
`endif
    end
    if (mag == 0) neg = 1'b0;
    m = 64'(mag);
    return {ov, neg, m[N-2:0]};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Input side: every accepted pair enqueues its expected response.
  always @(negedge clk) begin
    exp_t e;
    logic [N:0] r;
    if (rst_n && in_valid && in_ready) begin
      r = model(a, b);
      e.c   = dir_valid ? dir_c : r[N-1:0];
      e.ovf = dir_valid ? dir_ovf : r[N];
      e.cyc = cyc + 2;
      e.lat = lat_check;
      sb.push_back(e);
    end
  end

  // Output side: stall rules and ordered comparison against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid_held", 64'(out_valid), 64'd1);
        chk("stall_c_stable", 64'(c), 64'(prev_c));
        chk("stall_ovf_stable", 64'(ovf), 64'(prev_ovf));
      end
      if (out_valid && !out_ready)
        chk("stall_in_ready_low", 64'(in_ready), 64'd0);
      if (out_valid && out_ready) begin
        n_out++;
        if (sb.size() == 0) begin
          chk("unexpected_result", 64'(c), 64'hDEAD);
        end else begin
          e = sb.pop_front();
          chk("result_c", 64'(c), 64'(e.c));
          chk("result_ovf", 64'(ovf), 64'(e.ovf));
          if (e.lat) chk("latency", 64'(cyc), 64'(e.cyc));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_c     = c;
      prev_ovf   = ovf;
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue(input logic [N-1:0] ta, input logic [N-1:0] tb_v);
    int waited;
    a = ta;
    b = tb_v;
    in_valid = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 100) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) chk("accept_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    dir_valid = 1'b0;
  endtask

  task automatic issue_dir(input logic [N-1:0] ta, input logic [N-1:0] tb_v,
                           input logic [N-1:0] ec, input logic eo);
    dir_valid = 1'b1;
    dir_c     = ec;
    dir_ovf   = eo;
    issue(ta, tb_v);
  endtask

  task automatic drain;
    int k;
    k = 0;
    while (sb.size() != 0 && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  function automatic logic [N-1:0] rnd_word;
    logic [N-1:0] w;
    w = $urandom;
    case ($urandom_range(0, 5))
      0: w[N-2:0] = '1;
      1: w[N-2:0] = '0;
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    int n0;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1;
    lat_check = 1'b1; dir_valid = 1'b0; dir_c = '0; dir_ovf = 1'b0; bp_on = 1'b0;
    #2;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_c", 64'(c), 64'd0);
    chk("reset_ovf", 64'(ovf), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    issue_dir(32'h0000C000, 32'h80002000, 32'h0000A000, 1'b0); drain();
    issue_dir(32'h80008000, 32'h80008000, 32'h80010000, 1'b0); drain();
    issue_dir(32'h00004000, 32'h80004000, 32'h00000000, 1'b0); drain();
    issue_dir(32'h80000000, 32'h00003000, 32'h00003000, 1'b0); drain();
`ifdef FXP_ADD_SAT_EN
    issue_dir(32'h7FFFFFFF, 32'h00000001, 32'h7FFFFFFF, 1'b1); drain();
    issue_dir(32'hFFFFFFFF, 32'h80000005, 32'hFFFFFFFF, 1'b1); drain();
`else
    issue_dir(32'h7FFFFFFF, 32'h00000001, 32'h00000000, 1'b1); drain();
    issue_dir(32'hFFFFFFFF, 32'h80000005, 32'h80000004, 1'b1); drain();
`endif
    issue_dir(32'h7FFFFFFF, 32'h80000001, 32'h7FFFFFFE, 1'b0); drain();
    issue_dir(32'h80000000, 32'h80000000, 32'h00000000, 1'b0); drain();

    // Back-to-back stream: one result per cycle, fixed latency.
    for (int i = 0; i < 20; i++) issue(rnd_word(), rnd_word());
    drain();

    // Backpressure: in_valid stays high while out_ready toggles.
    lat_check = 1'b0;
    n0 = n_out;
    bp_on = 1'b1;
    fork
      begin
        for (int i = 0; i < 8; i++) issue(rnd_word(), rnd_word());
        bp_on = 1'b0;
      end
      begin
        while (bp_on) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    drain();
    chk("bp_result_count", 64'(n_out - n0), 64'd8);
    lat_check = 1'b1;

    // Reset with two pairs in flight.
    out_ready = 1'b0;
    issue(rnd_word(), rnd_word());
    issue(rnd_word(), rnd_word());
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_c", 64'(c), 64'd0);
    chk("midrst_ovf", 64'(ovf), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_no_stale", 64'(out_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    issue(32'h0000C000, 32'h00004000);
    drain();

    chk("final_queue_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
